// File: rtl/counter_checker_if.sv
// counter_checker_if: observed counter stream in, link integrity status out
interface counter_checker_if #(
    parameter int WIDTH     = 3,
    parameter int ERR_WIDTH = 8
);
    logic                 in_valid;
    logic [WIDTH-1:0]     in_value;
    logic                 clear_errs;
    logic                 locked;
    logic                 error_pulse;
    logic [ERR_WIDTH-1:0] err_count;
    logic [WIDTH-1:0]     expected;
    modport master (
        output in_valid, in_value, clear_errs,
        input  locked, error_pulse, err_count, expected
    );
    modport slave (
        input  in_valid, in_value, clear_errs,
        output locked, error_pulse, err_count, expected
    );
endinterface

// File: rtl/counter_checker.sv
// counter_checker: locks onto a +1 counter stream and counts sequence breaks
module counter_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 8
) (
    input logic              clk,
    input logic              rst_n,
    counter_checker_if.slave bus
);
    localparam int RW = LOCK_COUNT > 1 ? $clog2(LOCK_COUNT) : 1;
    localparam logic [RW:0] LC = (RW+1)'(LOCK_COUNT);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    state_t               state_q, state_d;
    logic [RW-1:0]        run_q, run_d;
    logic [RW:0]          run_inc;
    logic [WIDTH-1:0]     exp_q;
    logic [ERR_WIDTH-1:0] err_q, err_base;
    logic                 locked_q, pulse_q, match, brk;
    assign match    = bus.in_value == exp_q;
    assign run_inc  = {1'b0, run_q} + 1'b1;
    assign brk      = bus.in_valid && state_q == LOCKED && !match;
    // clear takes effect before a coincident break is counted
    assign err_base = bus.clear_errs ? '0 : err_q;
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    run_d   = '0;
                end
                ACQUIRE: begin
                    if (!match) run_d = '0;
                    else if (run_inc == LC) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end
                    else run_d = run_inc[RW-1:0];
                end
                LOCKED: begin
                    if (!match) begin
                        state_d = ACQUIRE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            exp_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            locked_q <= state_d == LOCKED;
            pulse_q  <= brk;
            if (bus.in_valid) exp_q <= bus.in_value + 1'b1;
            err_q    <= (brk && !(&err_base)) ? err_base + 1'b1 : err_base;
        end
    end
    assign bus.locked      = locked_q;
    assign bus.error_pulse = pulse_q;
    assign bus.err_count   = err_q;
    assign bus.expected    = exp_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed vectors with hand-computed expectations
module tb_counter_checker;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    counter_checker_if #(.WIDTH(3), .ERR_WIDTH(2)) b ();
    counter_checker_if #(.WIDTH(3), .ERR_WIDTH(2)) b1 ();
    assign b1.in_valid   = b.in_valid;
    assign b1.in_value   = b.in_value;
    assign b1.clear_errs = b.clear_errs;
    counter_checker #(.WIDTH(3), .LOCK_COUNT(4), .ERR_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );
    counter_checker #(.WIDTH(3), .LOCK_COUNT(1), .ERR_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic lk, input logic pl,
                           input logic [1:0] er, input logic [2:0] ex);
        chk({tag, ".locked"}, 32'(b.locked), 32'(lk));
        chk({tag, ".pulse"}, 32'(b.error_pulse), 32'(pl));
        chk({tag, ".errs"}, 32'(b.err_count), 32'(er));
        chk({tag, ".expected"}, 32'(b.expected), 32'(ex));
    endtask
    task automatic step(input logic v, input logic [2:0] val, input logic clr);
        b.in_valid   = v;
        b.in_value   = val;
        b.clear_errs = clr;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [2:0] e;
        logic [1:0] sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n = 1'b0;
        b.in_valid = 1'b0;
        b.in_value = '0;
        b.clear_errs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        // lock after 5 valid samples
        for (int i = 0; i < 5; i++) begin
            step(1, 3'(i), 0);
            chk_out($sformatf("t1.%0d", i), i == 4, 0, 0, 3'(i + 1));
        end
        // wrap 7->0 accepted
        for (int i = 5; i < 11; i++) begin
            step(1, 3'(i), 0);
            chk_out($sformatf("t2.%0d", i), 1, 0, 0, 3'(i + 1));
        end
        step(1, 3'd6, 0);
        chk_out("t3.brk", 0, 1, 1, 3'd7);
        for (int i = 0; i < 4; i++) begin
            step(1, 3'(7 + i), 0);
            chk_out($sformatf("t3.r%0d", i), i == 3, 0, 1, 3'(i));
        end
        // gaps are ignored; reset clears err_count
        rst_n = 1'b0;
        #1;
        chk_out("t4.rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 3'd0, 0); chk_out("t4.a", 0, 0, 0, 3'd1);
        chk("t4.lc1_a", 32'(b1.locked), 32'd0);
        step(1, 3'd1, 0); chk_out("t4.b", 0, 0, 0, 3'd2);
        chk("t4.lc1_b", 32'(b1.locked), 32'd1);
        step(0, 3'd5, 0); chk_out("t4.gap1", 0, 0, 0, 3'd2);
        step(1, 3'd2, 0); chk_out("t4.c", 0, 0, 0, 3'd3);
        step(1, 3'd3, 0); chk_out("t4.d", 0, 0, 0, 3'd4);
        step(0, 3'd6, 0); chk_out("t4.gap2", 0, 0, 0, 3'd4);
        step(1, 3'd4, 0); chk_out("t4.e", 1, 0, 0, 3'd5);
        // saturation of 2-bit error counter
        e = 3'd5;
        for (int k = 0; k < 5; k++) begin
            step(1, 3'(e + 3'd3), 0);
            e = 3'(e + 3'd4);
            chk_out($sformatf("t5.brk%0d", k), 0, 1, sat[k], e);
            for (int j = 0; j < 4; j++) begin
                step(1, e, 0);
                e = 3'(e + 3'd1);
                chk_out($sformatf("t5.rl%0d.%0d", k, j), j == 3, 0, sat[k], e);
            end
        end
        step(1, 3'(e + 3'd3), 1);
        e = 3'(e + 3'd4);
        chk_out("t5.clrbrk", 0, 1, 1, e);
        for (int j = 0; j < 4; j++) begin
            step(1, e, 0);
            e = 3'(e + 3'd1);
            chk_out($sformatf("t5.rlc%0d", j), j == 3, 0, 1, e);
        end
        step(0, 3'd0, 1);
        chk_out("t5.clr", 1, 0, 0, e);
        for (int k = 0; k < 2; k++) begin
            step(1, 3'(e + 3'd3), 0);
            e = 3'(e + 3'd4);
            chk_out($sformatf("t6.brk%0d", k), 0, 1, 2'(k + 1), e);
            for (int j = 0; j < 4; j++) begin
                step(1, e, 0);
                e = 3'(e + 3'd1);
                chk_out($sformatf("t6.rl%0d.%0d", k, j), j == 3, 0, 2'(k + 1), e);
            end
        end
        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t6.async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 3'(3 + i), 0);
            chk_out($sformatf("t6.re%0d", i), i == 4, 0, 0, 3'(4 + i));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side checker for a free-running binary up-counter stream, such as a counter output routed across the design.
- Acquires lock after a run of consecutive +1 samples, then flags every sequence break.
- Counts breaks in a saturating error counter.
- Sits at the consuming end of any counter link and provides link-integrity status to debug/status logic.

Parameters:
- WIDTH, 3, bit width of the monitored counter value; wraps modulo 2^WIDTH.
- LOCK_COUNT, 4, consecutive matching samples required to enter LOCKED; legal range 1..255.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_value is sampled on this clock edge when high.
- in_value  input  WIDTH  observed counter value.
- clear_errs  input  1  synchronous clear of err_count.
- locked  output  1  high while checker is in LOCKED.
- error_pulse  output  1  one-cycle pulse per detected break while LOCKED.
- err_count  output  ERR_WIDTH  number of breaks since reset/clear; saturates at all-ones.
- expected  output  WIDTH  next value the checker expects.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All other logic is synchronous to the clk rising edge.
- All outputs are registered.
- Reset values: state=IDLE, locked=0, error_pulse=0, err_count=0, expected=0, internal run counter=0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Cycles with in_valid=0:
  - State, run, expected and err_count hold.
  - error_pulse=0.
  - clear_errs still acts.
- "match" means in_value == expected on a valid sample.
- expected always updates to in_value+1 mod 2^WIDTH on every valid sample, in all states. This means the checker resyncs to the observed stream.
- Wrap-around: expected = 2^WIDTH-1 followed by in_value = 0 is a match.
- IDLE:
  - Valid sample -> ACQUIRE, run=0.
  - No match check is made, because no reference exists yet.
- ACQUIRE:
  - Valid and match -> run=run+1. If run+1 == LOCK_COUNT -> LOCKED and run=0.
  - Valid and mismatch -> run=0, stay in ACQUIRE. No error_pulse, no err_count change.
- LOCKED:
  - Valid and match -> stay in LOCKED.
  - Valid and mismatch -> ACQUIRE, run=0. Next cycle: error_pulse=1 and err_count increments.
- locked reflects the state register: it rises at the same edge that enters LOCKED and falls at the edge that samples the mismatch.
- Latency: a break sampled at edge N produces error_pulse high during cycle N..N+1 and the updated err_count from edge N.
- err_count saturation: at all-ones, further breaks still pulse error_pulse, but the count holds.
- clear_errs alone: err_count=0 at the next edge.
- clear_errs in the same cycle as a break: err_count=1, i.e. clear first, then count.
- clear_errs does not affect state, locked or expected.
- LOCK_COUNT=1: the first matching sample after IDLE locks.
- Implementation uses an explicit enumerated FSM (IDLE, ACQUIRE, LOCKED).
- The run counter is sized for LOCK_COUNT.
- There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset release, in_valid=1 every cycle, values 0,1,2,3,4,5,… (WIDTH=3, LOCK_COUNT=4) -> locked rises at the 5th valid edge. error_pulse stays 0 and err_count=0 throughout. expected tracks in_value+1.
2. Locked stream runs 5,6,7,0,1 -> the 7->0 wrap is accepted; locked stays 1 and err_count stays 0.
3. Locked, expected=3, in_value=6 injected -> locked=0 at that edge; error_pulse=1 for exactly one cycle; err_count=1; expected=7. Continuing 7,0,1,2 relocks after the 4th match.
4. Valid gaps: stream 0,1,X,2,3,X,4 with in_valid low on the X cycles (X values are garbage) -> no errors; lock is achieved as if the gaps were absent.
5. ERR_WIDTH=2, locked, then 5 forced breaks, each followed by relock -> err_count reads 1,2,3,3,3 and error_pulse fires 5 times. clear_errs coincident with the 6th break -> err_count=1.
6. rst_n pulsed low mid-cycle while LOCKED with err_count=2 -> all outputs reach their reset values before the next clk edge. After release, state is IDLE and relock needs LOCK_COUNT+1 valid samples.
